multiplicador_secuencial: RTL and testbench

Sequential shift-and-add multiplier-accumulator computing P = A·B + C for unsigned N-bit operands in a fixed N+1 cycles. It is the inverse operator of the sequential divider: feeding it the divider's Q, B and R reconstructs the original dividend A. It shares the divider's valid/done handshake, so the same control logic and bench style drive both blocks.

---
 rtl/mult_pkg.sv | 17 +
 rtl/multiplicador_secuencial.sv | 135 +++++++++++++
 tb/tb_multiplicador_secuencial.sv | 191 +++++++++++++++++++
 3 files changed

// File: rtl/mult_pkg.sv
// Shared definitions for the sequential shift-and-add multiplier-accumulator.
// Holds the FSM state encoding and the helper that sizes the iteration
// counter so that it can represent the values 0..N.
package mult_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } mult_state_t;

    // Width of an iteration counter that must hold the values 0..n.
    function automatic int count_width(input int n);
        return $clog2(n + 1);
    endfunction

endpackage

// File: rtl/multiplicador_secuencial.sv
// Sequential multiplier-accumulator: P = A*B + C for unsigned N-bit operands.
// One shift-add iteration per clock, N iterations per request, so the
// latency is constant and independent of the operand values.
//
// Ports:
//   clk   : system clock, rising-edge active
//   rst   : asynchronous active-low reset
//   valid : request strobe, only honoured while idle
//   A     : multiplicand (N bits, unsigned)
//   B     : multiplier   (N bits, unsigned)
//   C     : addend       (N bits, unsigned)
//   P     : result A*B + C (2N bits), held until the next completion
//   done  : one-cycle pulse marking a fresh P
//   busy  : high while a request is being processed
//   fits  : high when P fits back in N bits, updated together with P
module multiplicador_secuencial
    import mult_pkg::*;
#(
    parameter int N = 8
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           valid,
    input  logic [N-1:0]   A,
    input  logic [N-1:0]   B,
    input  logic [N-1:0]   C,
    output logic [2*N-1:0] P,
    output logic           done,
    output logic           busy,
    output logic           fits
);

    localparam int CW = count_width(N);

    mult_state_t      state_r, state_s;
    logic [2*N-1:0]   acc_r, acc_s;
    logic [2*N-1:0]   mcand_r, mcand_s;
    logic [N-1:0]     mult_r, mult_s;
    logic [CW-1:0]    count_r, count_s;
    logic [2*N-1:0]   p_r, p_s;
    logic             fits_r, fits_s;
    logic             done_r, done_s;
    logic             busy_r, busy_s;
    logic [2*N-1:0]   sum_s;

    // Next-state, datapath and output-register update logic.
    always_comb begin
        state_s = state_r;
        acc_s   = acc_r;
        mcand_s = mcand_r;
        mult_s  = mult_r;
        count_s = count_r;
        p_s     = p_r;
        fits_s  = fits_r;
        done_s  = 1'b0;
        busy_s  = busy_r;
        // Conditional add of the current partial product; only used in CALC.
        if (mult_r[0]) begin
            sum_s = acc_r + mcand_r;
        end else begin
            sum_s = acc_r;
        end

        case (state_r)
            IDLE: begin
                if (valid) begin
                    mcand_s = {{N{1'b0}}, A};
                    mult_s  = B;
                    acc_s   = {{N{1'b0}}, C};
                    count_s = {CW{1'b0}};
                    busy_s  = 1'b1;
                    state_s = CALC;
                end else begin
                    busy_s  = 1'b0;
                    state_s = IDLE;
                end
            end
            CALC: begin
                acc_s   = sum_s;
                mcand_s = {mcand_r[2*N-2:0], 1'b0};
                mult_s  = {1'b0, mult_r[N-1:1]};
                count_s = count_r + {{(CW-1){1'b0}}, 1'b1};
                // Last iteration: publish the result on this same edge.
                if (count_r == CW'(N - 1)) begin
                    p_s     = sum_s;
                    fits_s  = (sum_s[2*N-1:N] == {N{1'b0}});
                    done_s  = 1'b1;
                    state_s = DONE;
                end else begin
                    state_s = CALC;
                end
            end
            DONE: begin
                // Requests arriving here are dropped; accept only from IDLE.
                busy_s  = 1'b0;
                state_s = IDLE;
            end
            default: begin
                busy_s  = 1'b0;
                state_s = IDLE;
            end
        endcase
    end

    // State, datapath and output registers with asynchronous clear.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_r <= IDLE;
            acc_r   <= {(2*N){1'b0}};
            mcand_r <= {(2*N){1'b0}};
            mult_r  <= {N{1'b0}};
            count_r <= {CW{1'b0}};
            p_r     <= {(2*N){1'b0}};
            fits_r  <= 1'b0;
            done_r  <= 1'b0;
            busy_r  <= 1'b0;
        end else begin
            state_r <= state_s;
            acc_r   <= acc_s;
            mcand_r <= mcand_s;
            mult_r  <= mult_s;
            count_r <= count_s;
            p_r     <= p_s;
            fits_r  <= fits_s;
            done_r  <= done_s;
            busy_r  <= busy_s;
        end
    end

    assign P    = p_r;
    assign fits = fits_r;
    assign done = done_r;
    assign busy = busy_r;

endmodule

// File: tb/tb_multiplicador_secuencial.sv
// Scoreboard bench for multiplicador_secuencial. The driver pushes the
// arithmetic result a*b+c and the expected completion cycle whenever a
// request is accepted; an independent monitor pops and compares on done.
module tb_multiplicador_secuencial;

    localparam int N = 8;

    logic           clk;
    logic           rst;
    logic           valid;
    logic [N-1:0]   A, B, C;
    logic [2*N-1:0] P;
    logic           done, busy, fits;

    int tests;
    int fails;
    int cyc;

    logic [2*N-1:0] exp_p_q[$];
    logic           exp_f_q[$];
    int             exp_c_q[$];

    multiplicador_secuencial #(.N(N)) dut (
        .clk(clk), .rst(rst), .valid(valid),
        .A(A), .B(B), .C(C),
        .P(P), .done(done), .busy(busy), .fits(fits)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc = cyc + 1;

    task automatic chk(input string name, input longint act, input longint exp);
        tests = tests + 1;
        if (act != exp) begin
            fails = fails + 1;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference model: plain arithmetic on wide integers.
    task automatic push_expected(input int a, input int b, input int c);
        longint r;
        r = longint'(a) * longint'(b) + longint'(c);
        exp_p_q.push_back(r[2*N-1:0]);
        exp_f_q.push_back(r < (longint'(1) << N));
        exp_c_q.push_back(cyc + 1 + N);
    endtask

    // Monitor: pulse shape, busy duration and scoreboard comparisons.
    int  run;
    logic prev_done;
    always @(negedge clk) begin
        if (!rst) begin
            run = 0;
            prev_done = 1'b0;
        end else begin
            if (busy) begin
                run = run + 1;
            end else if (run != 0) begin
                chk("busy_len", run, N + 1);
                run = 0;
            end
            if (prev_done) begin
                chk("done_width", done, 0);
                chk("busy_after_done", busy, 0);
            end
            if (done) begin
                if (exp_p_q.size() == 0) begin
                    chk("unexpected_done", 1, 0);
                end else begin
                    chk("P", P, exp_p_q.pop_front());
                    chk("fits", fits, exp_f_q.pop_front());
                    chk("latency", cyc, exp_c_q.pop_front());
                end
            end
            prev_done = done;
        end
    end

    task automatic send(input int a, input int b, input int c);
        int n;
        n = 0;
        @(negedge clk);
        while (busy && n < 100) begin
            @(negedge clk);
            n = n + 1;
        end
        if (busy) chk("send_timeout", 1, 0);
        A = N'(a); B = N'(b); C = N'(c); valid = 1'b1;
        push_expected(a, b, c);
        @(negedge clk);
        valid = 1'b0;
        A = N'($urandom); B = N'($urandom); C = N'($urandom);
    endtask

    task automatic drain();
        int n;
        n = 0;
        while ((exp_p_q.size() != 0 || busy) && n < 200) begin
            @(negedge clk);
            n = n + 1;
        end
        if (exp_p_q.size() != 0) chk("drain_timeout", exp_p_q.size(), 0);
        @(negedge clk);
    endtask

    int da[9] = '{10, 15, 7, 15, 0, 255, 0, 255, 16};
    int db[9] = '{10,  8, 7, 16, 2, 255, 5,   1, 16};
    int dc[9] = '{ 0,  7, 1, 15, 1, 255, 0,   0,  0};

    initial begin
        logic [2*N-1:0] hold_p;
        logic           hold_f;
        int             last_acc;
        tests = 0; fails = 0; cyc = 0;
        rst = 1'b0; valid = 1'b0;
        A = '0; B = '0; C = '0;

        repeat (2) @(negedge clk);
        chk("rst_P", P, 0);
        chk("rst_fits", fits, 0);
        chk("rst_done", done, 0);
        chk("rst_busy", busy, 0);
        rst = 1'b1;

        // Directed cases including round-trips and boundaries.
        for (int i = 0; i < 9; i++) begin
            send(da[i], db[i], dc[i]);
            drain();
        end

        // Random single requests.
        for (int i = 0; i < 20; i++) begin
            send($urandom_range(255), $urandom_range(255), $urandom_range(255));
            drain();
        end

        // Valid held high, operands changing every cycle.
        last_acc = -1;
        for (int i = 0; i < 60; i++) begin
            @(negedge clk);
            A = N'($urandom); B = N'($urandom); C = N'($urandom);
            valid = 1'b1;
            if (!busy) begin
                push_expected(int'(A), int'(B), int'(C));
                if (last_acc >= 0) chk("accept_spacing", cyc - last_acc, N + 2);
                last_acc = cyc;
            end
        end
        @(negedge clk);
        valid = 1'b0;
        drain();

        // Abort mid-CALC with a half-cycle reset pulse.
        send(100, 2, 0);
        repeat (3) @(negedge clk);
        @(posedge clk);
        #2 rst = 1'b0;
        #1;
        chk("abort_P", P, 0);
        chk("abort_fits", fits, 0);
        chk("abort_done", done, 0);
        chk("abort_busy", busy, 0);
        exp_p_q.delete(); exp_f_q.delete(); exp_c_q.delete();
        #4 rst = 1'b1;
        for (int i = 0; i < 2 * N; i++) begin
            @(negedge clk);
            chk("abort_no_done", done, 0);
        end
        send(3, 4, 5);
        drain();
        chk("post_abort_P", P, 17);

        // Idle stability after completion.
        hold_p = P;
        hold_f = fits;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            chk("idle_P", P, hold_p);
            chk("idle_fits", fits, hold_f);
            chk("idle_done", done, 0);
            chk("idle_busy", busy, 0);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
